// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit accumulator CPU and its program sequencer:
// opcode values, sequencer state encoding and instruction word field helpers.
package cpu8_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction word layout: {operand, opcode}
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 3;
  localparam int OPD_LSB = 4;
  localparam int OPD_MSB = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  function automatic logic [3:0] opc_of(input logic [7:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [3:0] opd_of(input logic [7:0] w);
    return w[OPD_MSB:OPD_LSB];
  endfunction

endpackage

// File: rtl/cpu8_prog_ram.sv
// Program store: DEPTH x 8 RAM, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module cpu8_prog_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  // Write port: one word per clock when enabled
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu8_prog_sequencer.sv
// Program loader and instruction sequencer for the 8-bit accumulator CPU.
// The CPU takes an opcode one cycle and its operand the next, so playback
// holds each word's operand in opnd_q and emits it alongside the following
// opcode (or a NOP when there is no following opcode).
module cpu8_prog_sequencer
  import cpu8_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              abort,
  input  logic              load_start,
  input  logic [7:0]        load_data,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              run_start,
  input  logic              loop,
  output logic [7:0]        instr_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   prog_len
);

  localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [3:0]        opnd_q, opnd_d;
  logic [7:0]        instr_q, instr_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ram_we;
  logic [7:0]        rd_word;
  logic              last_word;

  // The write pointer coincides with the current load count
  cpu8_prog_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (len_q[ADDR_W-1:0]),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (rd_word)
  );

  assign last_word = ({1'b0, pc_q} == (len_q - LEN_ONE));

  // Next-state, playback and load control; every output is computed from
  // the next state so that all outputs leave the block registered
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    opnd_d  = opnd_q;
    instr_d = 8'h00;
    ram_we  = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (load_start) begin
            state_d = ST_LOAD;
            len_d   = '0;
          end else if (run_start && (len_q != '0)) begin
            state_d = ST_RUN;
            pc_d    = '0;
            opnd_d  = '0;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            len_d = '0;
          end else if (load_valid && ready_q) begin
            ram_we = 1'b1;
            len_d  = len_q + LEN_ONE;
            if (load_last || (len_d == LEN_FULL)) state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!ena) begin
            // Stall: deliver the pending operand under a NOP
            instr_d = {opnd_q, OP_NOP};
          end else if (opc_of(rd_word) == OP_HALT) begin
            instr_d = {opnd_q, OP_NOP};
            state_d = ST_DONE;
          end else begin
            instr_d = {opnd_q, opc_of(rd_word)};
            opnd_d  = opd_of(rd_word);
            if (last_word) begin
              if (loop) pc_d = '0;
              else      state_d = ST_DRAIN;
            end else begin
              pc_d = pc_q + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          instr_d = {opnd_q, OP_NOP};
          if (ena) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    ready_d = (state_d == ST_LOAD) && (len_d < LEN_FULL);
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      opnd_q  <= '0;
      instr_q <= 8'h00;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      opnd_q  <= opnd_d;
      instr_q <= instr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign load_ready = ready_q;
  assign instr_out  = instr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pc         = pc_q;
  assign prog_len   = len_q;

endmodule

// File: tb/tb_cpu8_prog_sequencer.sv
// Directed bench for cpu8_prog_sequencer with a small accumulator CPU model
// fed from instr_out.
module tb_cpu8_prog_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       abort = 1'b0;
  logic       load_start = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_valid = 1'b0;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       run_start = 1'b0;
  logic       loop = 1'b0;
  logic [7:0] instr_out;
  logic       busy;
  logic       done;
  logic [3:0] pc;
  logic [4:0] prog_len;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] reg_a = 8'h00;
  logic [3:0] pend_op = 4'h0;

  cpu8_prog_sequencer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .abort      (abort),
    .load_start (load_start),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_ready (load_ready),
    .run_start  (run_start),
    .loop       (loop),
    .instr_out  (instr_out),
    .busy       (busy),
    .done       (done),
    .pc         (pc),
    .prog_len   (prog_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_reset();
    reg_a   = 8'h00;
    pend_op = 4'h0;
  endtask

  // CPU: the opcode seen last cycle executes with this cycle's operand nibble
  task automatic cpu_model();
    logic [7:0] opd;
    opd = {4'h0, instr_out[7:4]};
    case (pend_op)
      4'h1: reg_a = reg_a + opd;
      4'h2: reg_a = reg_a - opd;
      4'h3: reg_a = reg_a & opd;
      4'h4: reg_a = reg_a | opd;
      4'h5: reg_a = ~reg_a;
      default: ;
    endcase
    pend_op = instr_out[3:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cpu_model();
  endtask

  task automatic load3(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data = w0; step();
    load_data = w1; step();
    load_data = w2; load_last = 1'b1; step();
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_instr", 16'(instr_out), 16'h00);
    chk("rst_ready", 16'(load_ready), 16'h0);
    chk("rst_busy",  16'(busy), 16'h0);
    chk("rst_done",  16'(done), 16'h0);
    chk("rst_pc",    16'(pc), 16'h0);
    chk("rst_len",   16'(prog_len), 16'h0);
    #5 rst_n = 1'b1;

    // Basic program
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("ld_ready", 16'(load_ready), 16'h1);
    chk("ld_busy",  16'(busy), 16'h1);
    load_valid = 1'b1;
    load_data = 8'h31; step();
    load_data = 8'h22; step();
    load_data = 8'h45; load_last = 1'b1; step();
    load_valid = 1'b0; load_last = 1'b0;
    chk("ld_len3",   16'(prog_len), 16'd3);
    chk("ld_idle_rdy", 16'(load_ready), 16'h0);
    chk("ld_idle_busy", 16'(busy), 16'h0);

    cpu_reset();
    run_start = 1'b1; loop = 1'b0; ena = 1'b1;
    step();
    run_start = 1'b0;
    chk("b_start_instr", 16'(instr_out), 16'h00);
    chk("b_start_busy",  16'(busy), 16'h1);
    step(); chk("b_i0", 16'(instr_out), 16'h01);
    chk("b_pc1", 16'(pc), 16'd1);
    step(); chk("b_i1", 16'(instr_out), 16'h32);
    step(); chk("b_i2", 16'(instr_out), 16'h25);
    step(); chk("b_i3", 16'(instr_out), 16'h40);
    step(); chk("b_i4", 16'(instr_out), 16'h00);
    chk("b_done", 16'(done), 16'h1);
    chk("b_busy", 16'(busy), 16'h0);
    chk("b_rega", 16'(reg_a), 16'hFE);

    // Stall
    cpu_reset();
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    step(); chk("s_i0", 16'(instr_out), 16'h01);
    step(); chk("s_i1", 16'(instr_out), 16'h32);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("s_stall", 16'(instr_out), 16'h20);
      chk("s_pc_hold", 16'(pc), 16'd2);
    end
    ena = 1'b1;
    step(); chk("s_i2", 16'(instr_out), 16'h25);
    step(); chk("s_i3", 16'(instr_out), 16'h40);
    step(); chk("s_i4", 16'(instr_out), 16'h00);
    chk("s_done", 16'(done), 16'h1);
    chk("s_rega", 16'(reg_a), 16'hFE);

    // HALT
    load3(8'h71, 8'h0F, 8'h52);
    chk("h_len", 16'(prog_len), 16'd3);
    cpu_reset();
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    step(); chk("h_i0", 16'(instr_out), 16'h01);
    step(); chk("h_i1", 16'(instr_out), 16'h70);
    chk("h_done_now", 16'(done), 16'h1);
    step(); chk("h_i2", 16'(instr_out), 16'h00);
    chk("h_busy", 16'(busy), 16'h0);
    chk("h_rega", 16'(reg_a), 16'h07);

    // Full load of 16 words, word i = {i, ADD}
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_data = {4'(i), 4'h1};
      step();
      if (i == 14) chk("f_ready15", 16'(load_ready), 16'h1);
    end
    load_valid = 1'b0;
    chk("f_len16", 16'(prog_len), 16'd16);
    chk("f_ready0", 16'(load_ready), 16'h0);
    chk("f_busy0", 16'(busy), 16'h0);

    // Loop playback
    loop = 1'b1;
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    for (int i = 0; i < 16; i++) step();
    chk("l_i15", 16'(instr_out), 16'hE1);
    chk("l_pc_wrap", 16'(pc), 16'd0);
    chk("l_busy", 16'(busy), 16'h1);
    step(); chk("l_i16", 16'(instr_out), 16'hF1);
    chk("l_pc1", 16'(pc), 16'd1);
    step(); chk("l_i17", 16'(instr_out), 16'h01);

    // Abort mid-RUN, then replay from word 0 with operand cleared
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("a_instr", 16'(instr_out), 16'h00);
    chk("a_busy", 16'(busy), 16'h0);
    chk("a_done", 16'(done), 16'h0);
    chk("a_len", 16'(prog_len), 16'd16);
    loop = 1'b0;
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    chk("a_pc0", 16'(pc), 16'd0);
    step(); chk("a_replay", 16'(instr_out), 16'h01);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Asynchronous reset mid-LOAD
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data = 8'hA3;
    step();
    load_valid = 1'b0;
    chk("r_len1", 16'(prog_len), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_ready", 16'(load_ready), 16'h0);
    chk("r_busy",  16'(busy), 16'h0);
    chk("r_len",   16'(prog_len), 16'd0);
    chk("r_instr", 16'(instr_out), 16'h00);
    chk("r_pc",    16'(pc), 16'd0);
    rst_n = 1'b1;

    // run_start with empty program is ignored
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    chk("e_busy", 16'(busy), 16'h0);
    step();
    chk("e_instr", 16'(instr_out), 16'h00);

    // abort beats load_start in the same cycle
    abort = 1'b1; load_start = 1'b1;
    step();
    abort = 1'b0; load_start = 1'b0;
    chk("p_busy", 16'(busy), 16'h0);
    chk("p_ready", 16'(load_ready), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu8_prog_sequencer.md
# cpu8_prog_sequencer

Program store and instruction sequencer that sits directly upstream of the 8-bit accumulator CPU and drives its 8-bit instruction input. The CPU samples an opcode from bits [3:0] one cycle and takes that opcode's operand from bits [7:4] on the following cycle. This block accepts a program over a valid/ready load port into a small RAM, then plays it back one word per enabled cycle. It re-times the operand nibble so that each opcode is paired with its own operand.

## Interface
- `DEPTH`, default 16: program words held; power of two.
- `ADDR_W`, default 4: log2(DEPTH).
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: cycle enable; low stalls playback.
- `abort` input 1: return to IDLE from any state.
- `load_start` input 1: pulse; enter LOAD.
- `load_data` input 8: program word, {operand[7:4], opcode[3:0]}.
- `load_valid` input 1: load_data valid.
- `load_last` input 1: qualifies the final word of the program.
- `load_ready` output 1: block can accept a word.
- `run_start` input 1: pulse; start playback.
- `loop` input 1: sampled on each last-word fetch; 1 = wrap to word 0.
- `instr_out` output 8: drives the CPU instruction input.
- `busy` output 1: state is LOAD, RUN or DRAIN.
- `done` output 1: state is DONE.
- `pc` output ADDR_W: next word to fetch.
- `prog_len` output ADDR_W+1: number of words loaded (0..DEPTH).

## Operation
- **States:** IDLE, LOAD, RUN, DRAIN, DONE. Command priority: abort > load_start > run_start.
- **Reset values:** state IDLE, instr_out 8'h00, pc 0, prog_len 0, load_ready 0, opnd_q 0. RAM contents are not reset.
- **Return to IDLE:** abort in any state forces IDLE and instr_out 8'h00. prog_len and RAM are kept.
- **IDLE/DONE:**
  - load_start → LOAD, write pointer 0, prog_len 0.
  - run_start with prog_len>0 → RUN, pc 0, opnd_q 0.
  - run_start with prog_len==0 is ignored.
  - instr_out is 8'h00.
- **LOAD:**
  - load_ready = 1 while prog_len < DEPTH.
  - A word is accepted on each edge with load_valid & load_ready: RAM[wptr] ← load_data, prog_len++.
  - Accepting a word with load_last, or accepting the DEPTH-th word, → IDLE.
  - load_start in LOAD restarts the load at pointer 0.
  - run_start in LOAD is ignored.
- **RUN, enabled edge:** let w = RAM[pc].
  - If w[3:0] == 4'hF (HALT): instr_out ← {opnd_q, 4'h0}, → DONE.
  - Otherwise: instr_out ← {opnd_q, w[3:0]}, opnd_q ← w[7:4].
  - If pc == prog_len-1 and loop=0: → DRAIN.
  - If pc == prog_len-1 and loop=1: pc ← 0.
  - Otherwise: pc++.
- **RUN, ena low:** instr_out ← {opnd_q, 4'h0}; pc and opnd_q hold. The pending opcode executes with its correct operand, and the CPU then sees NOPs.
- **DRAIN:** next enabled edge: instr_out ← {opnd_q, 4'h0}, → DONE.
- **Ignored commands:** load_start and run_start are ignored in RUN and DRAIN; only abort stops playback.
- **Opcode values:** 4'h0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT, F HALT (consumed by this block, never emitted). Other values pass through unchanged.

## Timing
- **Registered outputs:** instr_out, load_ready, done and busy are registered. No combinational path from any input to any output.
- **Start latency:** run_start sampled at edge t. The first opcode appears after edge t+1, as {0, op0}. Word k's operand appears one cycle after its opcode.
- **Program length:** N words without HALT produce N+1 non-idle output cycles (N opcodes, then the drain cycle). The next cycle shows 8'h00 with done=1.
- **Load throughput:** one word per cycle.
- **Edge-sensitivity:** commands are level-sampled; the controller asserts each one for exactly one cycle.

## Structure
- **Shared package `cpu8_pkg`:**
  - Opcode localparams: NOP, ADD, SUB, AND, OR, NOT, HALT.
  - State encoding.
  - Word field positions: OPC = [3:0], OPD = [7:4].
- **Sub-module `cpu8_prog_ram`:** DEPTH×8 RAM with one synchronous write port and one asynchronous read port. Everything else lives in the top level.

## Test plan
- **Basic program:** load 0x31, 0x22, 0x45 (last) → prog_len 3. run_start with loop=0 → instr_out 0x01, 0x32, 0x25, 0x40, then 0x00 with done=1. The attached CPU model ends with regA = 0xFE.
- **HALT:** load 0x71, 0x0F, 0x52 → output 0x01, then 0x70, then done. The word 0x52 is never emitted; regA = 7.
- **Stall:** same program as the basic test, ena low for 3 cycles after 0x32 → 0x20 repeated 3×, then 0x25 on resume. regA result is unchanged (0xFE).
- **Full load and loop:** load 16 words without load_last → load_ready drops after word 16, prog_len 16. Run with loop=1 → pc wraps 15→0 with no drain cycle.
- **Abort mid-RUN:** at the next edge instr_out = 0x00 and state is IDLE. A subsequent run_start replays from pc 0 with opnd_q cleared.
- **Reset and priority:**
  - rst_n low mid-LOAD → all outputs at their reset values immediately (asynchronous).
  - Same-cycle abort + load_start → IDLE.
  - run_start with prog_len 0 → stays IDLE.
